// File: rtl/mult_sequencer_pkg.sv
// mult_seq_pkg: shared types and constants for the shift-add multiplier
// control sequencer.
//   mult_state_t : sequencer state encoding (also published for debug)
//   DEFAULT_DW   : default operand width / iteration count
package mult_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GOT_X = 3'd1,
        READY = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } mult_state_t;

    localparam int DEFAULT_DW = 16;

endpackage

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: control bundle between the top-level handshake /
// datapath and the multiplier sequencer.
//   master : drives start, load, y_lsb; observes enables, status, debug
//   slave  : the sequencer side
//
// Handshake: start and load are single-cycle strobes sampled on the rising
// clock edge; there is no ready back-pressure. A strobe is either accepted
// (it moves the FSM and, for load, raises the matching register enable in
// the same cycle) or ignored; strobes that are illegal in the current state
// raise err one cycle later. done is a one-cycle pulse, busy is a level.
// dbg_state / dbg_cnt expose the FSM state and iteration count.
interface mult_sequencer_if #(
    parameter int CNT_W = 4
);
    import mult_seq_pkg::*;

    logic             start;
    logic             load;
    logic             y_lsb;
    logic             load_x_en;
    logic             load_y_en;
    logic             clear_acc;
    logic             shift_en;
    logic             add_en;
    logic             sel;
    logic             busy;
    logic             done;
    logic             err;
    mult_state_t      dbg_state;
    logic [CNT_W-1:0] dbg_cnt;

    modport master (
        output start, load, y_lsb,
        input  load_x_en, load_y_en, clear_acc, shift_en, add_en,
        input  sel, busy, done, err, dbg_state, dbg_cnt
    );

    modport slave (
        input  start, load, y_lsb,
        output load_x_en, load_y_en, clear_acc, shift_en, add_en,
        output sel, busy, done, err, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/mult_sequencer_iter_counter.sv
// iter_counter: iteration counter with synchronous clear and enable.
// Counts 0..DW-1 while enabled and returns to 0 after the terminal count,
// so it never wraps through a partial range.
//   clk     : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   i_clr   : synchronous clear (higher priority than i_en)
//   i_en    : advance one step
//   o_cnt   : current count
//   o_tc    : count equals DW-1
module iter_counter #(
    parameter int DW    = 16,
    parameter int CNT_W = $clog2(DW)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DW - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM for a shift-add multiplier datapath.
// Loads X then Y over a shared bus, waits for start, runs DW shift/add
// iterations, pulses done, and flags protocol misuse on err.
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : mult_sequencer_if.slave (start/load/y_lsb in; enables, sel,
//         busy, done, err and debug state/count out)
module mult_sequencer
    import mult_seq_pkg::*;
#(
    parameter  int DW    = DEFAULT_DW,
    localparam int CNT_W = $clog2(DW)
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_sequencer_if.slave      bus
);
    mult_state_t      r_state;
    mult_state_t      w_next;
    logic             r_err;
    logic             w_err_next;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_tc;
    logic [CNT_W-1:0] w_cnt;

    logic w_load_x_en, w_load_y_en, w_clear_acc, w_shift_en, w_add_en;
    logic w_sel, w_busy, w_done;

    // Counter restarts on an accepted start and only advances in RUN,
    // so it sits at 0 everywhere else.
    assign w_cnt_clr = (r_state == READY) && bus.start;
    assign w_cnt_en  = (r_state == RUN);

    iter_counter #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk     (clk),
        .i_rst_n (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.load)  w_next = GOT_X;
            GOT_X:   if (bus.load)  w_next = READY;
            READY:   if (bus.start) w_next = RUN;
            RUN:     if (w_tc)      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Misuse: start anywhere but READY, load while a multiply is in flight.
    // A load in READY is silently ignored so the held operands survive.
    always_comb begin
        w_err_next = (bus.start && (r_state != READY)) ||
                     (bus.load && ((r_state == RUN) || (r_state == DONE)));
    end

    // Output decode (Mealy on load/start/y_lsb where the state allows it)
    always_comb begin
        w_load_x_en = 1'b0;
        w_load_y_en = 1'b0;
        w_clear_acc = 1'b0;
        w_shift_en  = 1'b0;
        w_add_en    = 1'b0;
        w_sel       = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_load_x_en = bus.load;
            end
            GOT_X: begin
                w_sel       = 1'b1;
                w_load_y_en = bus.load;
            end
            READY: begin
                w_sel       = 1'b1;
                w_clear_acc = bus.start;
            end
            RUN: begin
                w_sel      = 1'b1;
                w_busy     = 1'b1;
                w_shift_en = 1'b1;
                w_add_en   = bus.y_lsb;
            end
            DONE: begin
                w_sel  = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.load_x_en = w_load_x_en;
    assign bus.load_y_en = w_load_y_en;
    assign bus.clear_acc = w_clear_acc;
    assign bus.shift_en  = w_shift_en;
    assign bus.add_en    = w_add_en;
    assign bus.sel       = w_sel;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = r_err;
    assign bus.dbg_state = r_state;
    assign bus.dbg_cnt   = w_cnt;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: self-checking bench for mult_sequencer with DW=8.
// A small shift-add datapath lives in the bench and is steered by the
// sequencer's enables; each multiply's product is compared with x*y.
module tb_mult_sequencer;
    import mult_seq_pkg::*;

    localparam int DW    = 8;
    localparam int CNT_W = $clog2(DW);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_sequencer_if #(.CNT_W(CNT_W)) bus_if ();

    mult_sequencer #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // ---------------- bench datapath ----------------
    logic [DW-1:0]   bus_data;
    logic [2*DW-1:0] xr;
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   yr;

    assign bus_if.y_lsb = yr[0];

    initial begin
        xr  = '0;
        yr  = '0;
        acc = '0;
    end

    always @(posedge clk) begin
        if (bus_if.load_x_en)     xr <= {{DW{1'b0}}, bus_data};
        else if (bus_if.shift_en) xr <= xr << 1;
        if (bus_if.load_y_en)     yr <= bus_data;
        else if (bus_if.shift_en) yr <= yr >> 1;
        if (bus_if.clear_acc)     acc <= '0;
        else if (bus_if.add_en)   acc <= acc + xr;
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // {load_x_en, load_y_en, clear_acc, shift_en, add_en, sel, busy, done, err}
    function automatic logic [8:0] outs();
        return {bus_if.load_x_en, bus_if.load_y_en, bus_if.clear_acc,
                bus_if.shift_en, bus_if.add_en, bus_if.sel, bus_if.busy,
                bus_if.done, bus_if.err};
    endfunction

    // ---------------- driver tasks ----------------
    // Each cycle: strobes cleared just after the edge, caller drives, then
    // waits #1 before sampling.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.load  = 1'b0;
    endtask

    // Full multiply with optional misuse:
    //   ld_k / st_k : RUN cycle (1..DW) carrying a stray load / start, 0 = none
    //   swl         : assert load together with start in READY
    //   done_ld     : stray load in the DONE cycle
    task automatic run_mult(input logic [DW-1:0] x, input logic [DW-1:0] y,
                            input int ld_k, input int st_k,
                            input bit swl, input bit done_ld);
        logic [8:0]      e;
        logic            pend_err;
        logic [2*DW-1:0] exp_p;
        exp_p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};

        next_cycle(); bus_if.load = 1'b1; bus_data = x; #1;
        check_eq("load_x", 32'(outs()), 32'(9'b100000000));
        check_eq("state_idle", 32'(bus_if.dbg_state), 32'(IDLE));

        next_cycle(); bus_if.load = 1'b1; bus_data = y; #1;
        check_eq("load_y", 32'(outs()), 32'(9'b010001000));

        next_cycle(); bus_if.start = 1'b1; bus_if.load = swl; bus_data = ~y; #1;
        check_eq("start", 32'(outs()), 32'(9'b001001000));
        check_eq("state_ready", 32'(bus_if.dbg_state), 32'(READY));

        pend_err = 1'b0;
        for (int k = 1; k <= DW; k++) begin
            next_cycle();
            bus_if.load  = (k == ld_k);
            bus_if.start = (k == st_k);
            bus_data     = DW'($urandom);
            #1;
            e = {3'b000, 1'b1, y[k-1], 1'b1, 1'b1, 1'b0, pend_err};
            check_eq("run_outs", 32'(outs()), 32'(e));
            check_eq("run_cnt", 32'(bus_if.dbg_cnt), 32'(k - 1));
            pend_err = bus_if.load | bus_if.start;
        end

        next_cycle(); bus_if.load = done_ld; bus_data = DW'($urandom); #1;
        check_eq("done", 32'(outs()), 32'({8'b00000101, pend_err}));
        check_eq("product", 32'(acc), 32'(exp_p));
        check_eq("done_cnt", 32'(bus_if.dbg_cnt), 32'(0));

        next_cycle(); #1;
        check_eq("after_done", 32'(outs()), 32'({8'b0, done_ld}));
        check_eq("after_state", 32'(bus_if.dbg_state), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_if.start = 1'b0;
        bus_if.load  = 1'b0;
        bus_data     = '0;

        // reset for two cycles, then idle
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        check_eq("reset_outs", 32'(outs()), 32'(0));
        check_eq("reset_state", 32'(bus_if.dbg_state), 32'(IDLE));
        check_eq("reset_cnt", 32'(bus_if.dbg_cnt), 32'(0));
        next_cycle(); #1;
        check_eq("idle_outs", 32'(outs()), 32'(0));

        // nominal multiply, y bits LSB-first 1,0,1,0,1,1,0,1
        run_mult(8'hD3, 8'hB5, 0, 0, 1'b0, 1'b0);

        // start in IDLE, then start with only X loaded
        next_cycle(); bus_if.start = 1'b1; #1;
        check_eq("st_idle_outs", 32'(outs()), 32'(0));
        next_cycle(); #1;
        check_eq("st_idle_err", 32'(outs()), 32'(9'b000000001));
        check_eq("st_idle_state", 32'(bus_if.dbg_state), 32'(IDLE));
        next_cycle(); bus_if.load = 1'b1; bus_data = 8'h11; #1;
        check_eq("ld_x_only", 32'(outs()), 32'(9'b100000000));
        next_cycle(); bus_if.start = 1'b1; #1;
        check_eq("st_gotx_outs", 32'(outs()), 32'(9'b000001000));
        next_cycle(); #1;
        check_eq("st_gotx_err", 32'(outs()), 32'(9'b000001001));
        check_eq("st_gotx_state", 32'(bus_if.dbg_state), 32'(GOT_X));
        next_cycle(); #1;
        check_eq("err_one_shot", 32'(outs()), 32'(9'b000001000));
        // reset out of GOT_X
        rst = 1'b0;
        next_cycle(); rst = 1'b1; #1;
        check_eq("rst_gotx_outs", 32'(outs()), 32'(0));
        check_eq("rst_gotx_state", 32'(bus_if.dbg_state), 32'(IDLE));

        // start+load together in READY
        run_mult(8'hFF, 8'hFF, 0, 0, 1'b1, 1'b0);
        // stray load in 4th RUN cycle
        run_mult(8'h5A, 8'h81, 4, 0, 1'b0, 1'b0);
        // stray start in last RUN cycle, stray load in DONE
        run_mult(8'h01, 8'h80, 0, DW, 1'b0, 1'b1);

        // reset in 5th RUN cycle
        next_cycle(); bus_if.load = 1'b1; bus_data = 8'h3C; #1;
        next_cycle(); bus_if.load = 1'b1; bus_data = 8'h5A; #1;
        next_cycle(); bus_if.start = 1'b1; #1;
        for (int k = 1; k <= 5; k++) begin
            next_cycle(); #1;
            check_eq("pre_rst_busy", 32'(bus_if.busy), 32'(1));
            if (k == 5) rst = 1'b0;
        end
        next_cycle(); rst = 1'b1; #1;
        check_eq("rst_run_outs", 32'(outs()), 32'(0));
        check_eq("rst_run_state", 32'(bus_if.dbg_state), 32'(IDLE));
        check_eq("rst_run_cnt", 32'(bus_if.dbg_cnt), 32'(0));
        for (int k = 0; k < DW; k++) begin
            next_cycle(); #1;
            check_eq("no_done", 32'(outs()), 32'(0));
        end
        run_mult(8'h3C, 8'h5A, 0, 0, 1'b0, 1'b0);

        // randomized multiplies with random misuse and idle gaps
        for (int n = 0; n < 16; n++) begin
            run_mult(DW'($urandom), DW'($urandom),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW) : 0,
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW) : 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                next_cycle(); #1;
                check_eq("gap_idle", 32'(outs()), 32'(0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
